// File: rtl/tcp_tx_seg_gen.sv
// tcp_tx_seg_gen: TX-side segment generator for the TCP engine.
// Accepts one flow command, reads the flow's TX/RX state and TX tail pointer,
// computes a window- and MSS-limited segment, emits one descriptor to the
// packet assembler and writes the advanced sequence number back.
// Optional feature macro: TCP_TX_RT_EN (go-back-N retransmit on sched_req_rt).
module tcp_tx_seg_gen #(
    parameter int FLOWID_W = 3,
    parameter int SEQ_W    = 32,
    parameter int WIN_W    = 16,
    parameter int PTR_W    = 16,
    parameter int MSS      = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sched_req_val,
    output logic                sched_req_rdy,
    input  logic [FLOWID_W-1:0] sched_req_flowid,
    input  logic                sched_req_need_ack,
    input  logic                sched_req_rt,
    output logic [FLOWID_W-1:0] state_rd_addr,
    input  logic [SEQ_W-1:0]    tx_state_rd_seq,
    input  logic [SEQ_W-1:0]    rx_state_rd_acked,
    input  logic [SEQ_W-1:0]    rx_state_rd_ack_num,
    input  logic [WIN_W-1:0]    rx_state_rd_their_win,
    input  logic [WIN_W-1:0]    rx_state_rd_our_win,
    input  logic [PTR_W:0]      tx_tail_rd_ptr,
    output logic                tx_pkt_val,
    input  logic                tx_pkt_rdy,
    output logic [FLOWID_W-1:0] tx_pkt_flowid,
    output logic [SEQ_W-1:0]    tx_pkt_seq,
    output logic [SEQ_W-1:0]    tx_pkt_ack,
    output logic [WIN_W-1:0]    tx_pkt_win,
    output logic [7:0]          tx_pkt_flags,
    output logic [PTR_W-1:0]    tx_pkt_payload_addr,
    output logic [15:0]         tx_pkt_payload_len,
    output logic                tx_seq_wr_val,
    output logic [FLOWID_W-1:0] tx_seq_wr_addr,
    output logic [SEQ_W-1:0]    tx_seq_wr_data
);

    localparam int LEN_W = 16;
    localparam logic [7:0] FLAG_ACK = 8'h10;
    localparam logic [7:0] FLAG_PSH = 8'h08;

    typedef enum logic [1:0] {IDLE, RD, CALC, OUT} state_t;

    state_t              state_q, state_d;
    logic                rdy_q, rdy_d;
    logic [FLOWID_W-1:0] flowid_q, flowid_d;
    logic                need_ack_q, need_ack_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [SEQ_W-1:0]    acked_q, acked_d;
    logic [SEQ_W-1:0]    ack_num_q, ack_num_d;
    logic [WIN_W-1:0]    their_win_q, their_win_d;
    logic [WIN_W-1:0]    our_win_q, our_win_d;
    logic [PTR_W:0]      tail_q, tail_d;
    logic                val_q, val_d;
    logic [SEQ_W-1:0]    pkt_seq_q, pkt_seq_d;
    logic [SEQ_W-1:0]    pkt_ack_q, pkt_ack_d;
    logic [WIN_W-1:0]    pkt_win_q, pkt_win_d;
    logic [7:0]          flags_q, flags_d;
    logic [PTR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SEQ_W-1:0]    wr_data_q, wr_data_d;

`ifdef TCP_TX_RT_EN
    logic                rt_q, rt_d;
`else
    wire                 unused_rt = sched_req_rt;
`endif

    logic [SEQ_W-1:0]    seq_eff;
    logic [PTR_W:0]      unsent;
    logic [SEQ_W-1:0]    inflight;
    logic [WIN_W-1:0]    usable;
    logic [LEN_W-1:0]    len_c;
    logic                send_c;

    // Segment sizing from the captured flow state: bytes queued, window room, MSS.
    always_comb begin
        seq_eff = seq_q;
`ifdef TCP_TX_RT_EN
        if (rt_q) begin
            seq_eff = acked_q;
        end
`endif
        // The extra wrap bit makes a full buffer distinct from an empty one.
        unsent   = tail_q - seq_eff[PTR_W:0];
        inflight = seq_eff - acked_q;
        usable   = '0;
        if ({{(SEQ_W-WIN_W){1'b0}}, their_win_q} > inflight) begin
            usable = their_win_q - inflight[WIN_W-1:0];
        end
        len_c = LEN_W'(MSS);
        if (32'(unsent) < 32'(len_c)) begin
            len_c = LEN_W'(unsent);
        end
        if (32'(usable) < 32'(len_c)) begin
            len_c = LEN_W'(usable);
        end
        // A pure ACK still goes out when one is owed; retransmits always probe.
        send_c = (len_c != '0) | need_ack_q;
`ifdef TCP_TX_RT_EN
        send_c = send_c | rt_q;
`endif
    end

    // Command sequencing: accept, read RAMs, size segment, hold descriptor.
    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        flowid_d    = flowid_q;
        need_ack_d  = need_ack_q;
        seq_d       = seq_q;
        acked_d     = acked_q;
        ack_num_d   = ack_num_q;
        their_win_d = their_win_q;
        our_win_d   = our_win_q;
        tail_d      = tail_q;
        val_d       = val_q;
        pkt_seq_d   = pkt_seq_q;
        pkt_ack_d   = pkt_ack_q;
        pkt_win_d   = pkt_win_q;
        flags_d     = flags_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_data_d   = wr_data_q;
`ifdef TCP_TX_RT_EN
        rt_d        = rt_q;
`endif
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (sched_req_val && rdy_q) begin
                    flowid_d   = sched_req_flowid;
                    need_ack_d = sched_req_need_ack;
`ifdef TCP_TX_RT_EN
                    rt_d       = sched_req_rt;
`endif
                    rdy_d      = 1'b0;
                    state_d    = RD;
                end
            end
            RD: begin
                seq_d       = tx_state_rd_seq;
                acked_d     = rx_state_rd_acked;
                ack_num_d   = rx_state_rd_ack_num;
                their_win_d = rx_state_rd_their_win;
                our_win_d   = rx_state_rd_our_win;
                tail_d      = tx_tail_rd_ptr;
                state_d     = CALC;
            end
            CALC: begin
                if (send_c) begin
                    val_d     = 1'b1;
                    pkt_seq_d = seq_eff;
                    pkt_ack_d = ack_num_q;
                    pkt_win_d = our_win_q;
                    flags_d   = (len_c != '0) ? (FLAG_ACK | FLAG_PSH) : FLAG_ACK;
                    addr_d    = seq_eff[PTR_W-1:0];
                    len_d     = len_c;
                    wr_data_d = seq_eff + SEQ_W'(len_c);
                    state_d   = OUT;
                end else begin
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (tx_pkt_rdy) begin
                    val_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any flow in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            flowid_q    <= '0;
            need_ack_q  <= 1'b0;
            seq_q       <= '0;
            acked_q     <= '0;
            ack_num_q   <= '0;
            their_win_q <= '0;
            our_win_q   <= '0;
            tail_q      <= '0;
            val_q       <= 1'b0;
            pkt_seq_q   <= '0;
            pkt_ack_q   <= '0;
            pkt_win_q   <= '0;
            flags_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wr_data_q   <= '0;
`ifdef TCP_TX_RT_EN
            rt_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            flowid_q    <= flowid_d;
            need_ack_q  <= need_ack_d;
            seq_q       <= seq_d;
            acked_q     <= acked_d;
            ack_num_q   <= ack_num_d;
            their_win_q <= their_win_d;
            our_win_q   <= our_win_d;
            tail_q      <= tail_d;
            val_q       <= val_d;
            pkt_seq_q   <= pkt_seq_d;
            pkt_ack_q   <= pkt_ack_d;
            pkt_win_q   <= pkt_win_d;
            flags_q     <= flags_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_data_q   <= wr_data_d;
`ifdef TCP_TX_RT_EN
            rt_q        <= rt_d;
`endif
        end
    end

    // The RAMs see the incoming flow id while idle so data lands in RD.
    assign sched_req_rdy       = rdy_q;
    assign state_rd_addr       = rdy_q ? sched_req_flowid : flowid_q;
    assign tx_pkt_val          = val_q;
    assign tx_pkt_flowid       = flowid_q;
    assign tx_pkt_seq          = pkt_seq_q;
    assign tx_pkt_ack          = pkt_ack_q;
    assign tx_pkt_win          = pkt_win_q;
    assign tx_pkt_flags        = flags_q;
    assign tx_pkt_payload_addr = addr_q;
    assign tx_pkt_payload_len  = len_q;
    // Writeback fires only in the handshake cycle and never while in reset.
    assign tx_seq_wr_val       = val_q & tx_pkt_rdy & (len_q != '0) & ~rst;
    assign tx_seq_wr_addr      = flowid_q;
    assign tx_seq_wr_data      = wr_data_q;

endmodule

// File: tb/tb_tcp_tx_seg_gen.sv
// tb_tcp_tx_seg_gen: scoreboard bench for tcp_tx_seg_gen.
// Stimulus pushes expected descriptors computed by a plain-arithmetic model;
// a negedge monitor pops and compares on every descriptor handshake.
module tb_tcp_tx_seg_gen;

    localparam int FLOWID_W = 3;
    localparam int SEQ_W    = 32;
    localparam int WIN_W    = 16;
    localparam int PTR_W    = 16;
    localparam int MSS      = 1024;
`ifdef TCP_TX_RT_EN
    localparam bit RT_EN = 1'b1;
`else
    localparam bit RT_EN = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                sched_req_val;
    logic                sched_req_rdy;
    logic [FLOWID_W-1:0] sched_req_flowid;
    logic                sched_req_need_ack;
    logic                sched_req_rt;
    logic [FLOWID_W-1:0] state_rd_addr;
    logic [SEQ_W-1:0]    tx_state_rd_seq;
    logic [SEQ_W-1:0]    rx_state_rd_acked;
    logic [SEQ_W-1:0]    rx_state_rd_ack_num;
    logic [WIN_W-1:0]    rx_state_rd_their_win;
    logic [WIN_W-1:0]    rx_state_rd_our_win;
    logic [PTR_W:0]      tx_tail_rd_ptr;
    logic                tx_pkt_val;
    logic                tx_pkt_rdy;
    logic [FLOWID_W-1:0] tx_pkt_flowid;
    logic [SEQ_W-1:0]    tx_pkt_seq;
    logic [SEQ_W-1:0]    tx_pkt_ack;
    logic [WIN_W-1:0]    tx_pkt_win;
    logic [7:0]          tx_pkt_flags;
    logic [PTR_W-1:0]    tx_pkt_payload_addr;
    logic [15:0]         tx_pkt_payload_len;
    logic                tx_seq_wr_val;
    logic [FLOWID_W-1:0] tx_seq_wr_addr;
    logic [SEQ_W-1:0]    tx_seq_wr_data;

    typedef struct {
        logic [FLOWID_W-1:0] flowid;
        logic [SEQ_W-1:0]    seq;
        logic [SEQ_W-1:0]    ack;
        logic [WIN_W-1:0]    win;
        logic [7:0]          flags;
        logic [PTR_W-1:0]    addr;
        logic [15:0]         len;
        logic [SEQ_W-1:0]    wr_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rdy_mode = 1;

    logic [SEQ_W-1:0] mem_seq     [8];
    logic [SEQ_W-1:0] mem_acked   [8];
    logic [SEQ_W-1:0] mem_ack_num [8];
    logic [WIN_W-1:0] mem_tw      [8];
    logic [WIN_W-1:0] mem_ow      [8];
    logic [PTR_W:0]   mem_tail    [8];

    tcp_tx_seg_gen #(
        .FLOWID_W(FLOWID_W), .SEQ_W(SEQ_W), .WIN_W(WIN_W), .PTR_W(PTR_W), .MSS(MSS)
    ) dut (
        .clk(clk), .rst(rst),
        .sched_req_val(sched_req_val), .sched_req_rdy(sched_req_rdy),
        .sched_req_flowid(sched_req_flowid), .sched_req_need_ack(sched_req_need_ack),
        .sched_req_rt(sched_req_rt), .state_rd_addr(state_rd_addr),
        .tx_state_rd_seq(tx_state_rd_seq), .rx_state_rd_acked(rx_state_rd_acked),
        .rx_state_rd_ack_num(rx_state_rd_ack_num), .rx_state_rd_their_win(rx_state_rd_their_win),
        .rx_state_rd_our_win(rx_state_rd_our_win), .tx_tail_rd_ptr(tx_tail_rd_ptr),
        .tx_pkt_val(tx_pkt_val), .tx_pkt_rdy(tx_pkt_rdy), .tx_pkt_flowid(tx_pkt_flowid),
        .tx_pkt_seq(tx_pkt_seq), .tx_pkt_ack(tx_pkt_ack), .tx_pkt_win(tx_pkt_win),
        .tx_pkt_flags(tx_pkt_flags), .tx_pkt_payload_addr(tx_pkt_payload_addr),
        .tx_pkt_payload_len(tx_pkt_payload_len), .tx_seq_wr_val(tx_seq_wr_val),
        .tx_seq_wr_addr(tx_seq_wr_addr), .tx_seq_wr_data(tx_seq_wr_data)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flow-state RAMs with one-cycle read latency.
    always @(posedge clk) begin
        tx_state_rd_seq       <= mem_seq[state_rd_addr];
        rx_state_rd_acked     <= mem_acked[state_rd_addr];
        rx_state_rd_ack_num   <= mem_ack_num[state_rd_addr];
        rx_state_rd_their_win <= mem_tw[state_rd_addr];
        rx_state_rd_our_win   <= mem_ow[state_rd_addr];
        tx_tail_rd_ptr        <= mem_tail[state_rd_addr];
    end

    // Assembler ready: 0 = stalled, 1 = always ready, 2 = random backpressure.
    initial begin
        tx_pkt_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       tx_pkt_rdy = 1'b0;
                1:       tx_pkt_rdy = 1'b1;
                default: tx_pkt_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference behaviour in plain integer arithmetic; returns whether a descriptor is due.
    function automatic bit model(input logic [FLOWID_W-1:0] flow, input logic [31:0] seq,
                                 input logic [31:0] acked, input logic [31:0] ack_num,
                                 input logic [15:0] tw, input logic [15:0] ow,
                                 input logic [16:0] tail, input bit need_ack, input bit rt,
                                 output exp_t e);
        longint s, unsent, inflight, usable, len;
        s        = (RT_EN && rt) ? longint'(acked) : longint'(seq);
        unsent   = (longint'(tail) - (s % 131072) + 131072) % 131072;
        inflight = (s - longint'(acked) + 64'sh1_0000_0000) % 64'sh1_0000_0000;
        usable   = (longint'(tw) > inflight) ? longint'(tw) - inflight : 0;
        len      = MSS;
        if (unsent < len) len = unsent;
        if (usable < len) len = usable;
        e.flowid  = flow;
        e.seq     = 32'(s);
        e.ack     = ack_num;
        e.win     = ow;
        e.flags   = (len > 0) ? 8'h18 : 8'h10;
        e.addr    = 16'(s % 65536);
        e.len     = 16'(len);
        e.wr_data = 32'((s + len) % 64'sh1_0000_0000);
        return (len > 0) || need_ack || (RT_EN && rt);
    endfunction

    // Load flow state, wait for the block to be idle, issue one command.
    // Entered and left just after a rising edge; leaves in the cycle after accept.
    task automatic applyStimulus(input logic [FLOWID_W-1:0] flow, input logic [31:0] seq,
                                 input logic [31:0] acked, input logic [31:0] ack_num,
                                 input logic [15:0] tw, input logic [15:0] ow,
                                 input logic [16:0] tail, input bit need_ack, input bit rt,
                                 output bit sent);
        exp_t e;
        int   n = 0;
        sent = 1'b0;
        while (!sched_req_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!sched_req_rdy) begin
            checkOutput("sched_rdy_timeout", 64'(sched_req_rdy), 64'd1);
            return;
        end
        mem_seq[flow]      = seq;
        mem_acked[flow]    = acked;
        mem_ack_num[flow]  = ack_num;
        mem_tw[flow]       = tw;
        mem_ow[flow]       = ow;
        mem_tail[flow]     = tail;
        sched_req_flowid   = flow;
        sched_req_need_ack = need_ack;
        sched_req_rt       = rt;
        sched_req_val      = 1'b1;
        sent = model(flow, seq, acked, ack_num, tw, ow, tail, need_ack, rt, e);
        if (sent) exp_q.push_back(e);
        @(posedge clk);
        #1;
        sched_req_val = 1'b0;
    endtask

    // Following an accept: block busy in RD/CALC, descriptor (or idle) in the third cycle.
    task automatic checkLatency(input bit sent);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("lat_val_c%0d", k), 64'(tx_pkt_val), 64'(k == 3 && sent));
            checkOutput($sformatf("lat_rdy_c%0d", k), 64'(sched_req_rdy), 64'(k == 3 && !sent));
        end
    endtask

    // Scoreboard monitor: compare every descriptor handshake against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (tx_pkt_val && tx_pkt_rdy) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_descriptor", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pkt_flowid", 64'(tx_pkt_flowid), 64'(e.flowid));
                    checkOutput("pkt_seq", 64'(tx_pkt_seq), 64'(e.seq));
                    checkOutput("pkt_ack", 64'(tx_pkt_ack), 64'(e.ack));
                    checkOutput("pkt_win", 64'(tx_pkt_win), 64'(e.win));
                    checkOutput("pkt_flags", 64'(tx_pkt_flags), 64'(e.flags));
                    checkOutput("pkt_addr", 64'(tx_pkt_payload_addr), 64'(e.addr));
                    checkOutput("pkt_len", 64'(tx_pkt_payload_len), 64'(e.len));
                    checkOutput("wr_val", 64'(tx_seq_wr_val), 64'(e.len != 0));
                    if (e.len != 0) begin
                        checkOutput("wr_data", 64'(tx_seq_wr_data), 64'(e.wr_data));
                        checkOutput("wr_addr", 64'(tx_seq_wr_addr), 64'(e.flowid));
                    end
                end
            end else if (tx_seq_wr_val) begin
                checkOutput("wr_without_handshake", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        bit               sent;
        int               n;
        logic [31:0]      seq, acked;
        logic [FLOWID_W-1:0] flow;
        int unsigned      off;

        rst = 1'b1;
        sched_req_val = 1'b0;
        sched_req_flowid = '0;
        sched_req_need_ack = 1'b0;
        sched_req_rt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_seq[i] = '0; mem_acked[i] = '0; mem_ack_num[i] = '0;
            mem_tw[i] = '0; mem_ow[i] = '0; mem_tail[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdy", 64'(sched_req_rdy), 64'd0);
        checkOutput("reset_val", 64'(tx_pkt_val), 64'd0);
        checkOutput("reset_wr_val", 64'(tx_seq_wr_val), 64'd0);
        checkOutput("reset_seq", 64'(tx_pkt_seq), 64'd0);
        checkOutput("reset_len", 64'(tx_pkt_payload_len), 64'd0);
        checkOutput("reset_flags", 64'(tx_pkt_flags), 64'd0);
        checkOutput("reset_rd_addr", 64'(state_rd_addr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rdy_after_reset", 64'(sched_req_rdy), 64'd1);

        $display("[TB] directed cases");
        rdy_mode = 1;
        applyStimulus(3'd1, 32'd1000, 32'd1000, 32'd77, 16'd8000, 16'd500, 17'd4000, 1'b0, 1'b0, sent);
        checkLatency(sent);
        applyStimulus(3'd2, 32'd5000, 32'd1000, 32'd9, 16'd4096, 16'd100, 17'd5500, 1'b0, 1'b0, sent);
        checkLatency(sent);
        applyStimulus(3'd3, 32'd7000, 32'd7000, 32'h55, 16'd1000, 16'd200, 17'd7000, 1'b1, 1'b0, sent);
        checkLatency(sent);
        applyStimulus(3'd3, 32'd7000, 32'd7000, 32'h55, 16'd1000, 16'd200, 17'd7000, 1'b0, 1'b0, sent);
        checkLatency(sent);
        applyStimulus(3'd4, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'd1, 16'hFFFF, 16'd7, 17'h0_0100, 1'b0, 1'b0, sent);
        checkLatency(sent);
        applyStimulus(3'd5, 32'd3000, 32'd2000, 32'd3, 16'd8000, 16'd0, 17'd3000, 1'b0, 1'b1, sent);
        checkLatency(sent);
        applyStimulus(3'd6, 32'd0, 32'd0, 32'd4, 16'hFFFF, 16'd1, 17'h1_0000, 1'b0, 1'b0, sent);
        checkLatency(sent);
        applyStimulus(3'd7, 32'd9000, 32'd1000, 32'd5, 16'd4000, 16'd2, 17'd9500, 1'b1, 1'b0, sent);
        checkLatency(sent);

        $display("[TB] backpressure hold");
        @(posedge clk);
        #1;
        rdy_mode = 0;
        applyStimulus(3'd2, 32'd200, 32'd100, 32'd11, 16'd3000, 16'd33, 17'd900, 1'b0, 1'b0, sent);
        n = 0;
        while (!tx_pkt_val && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("stall_val_seen", 64'(tx_pkt_val), 64'd1);
        repeat (10) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                checkOutput("stall_seq", 64'(tx_pkt_seq), 64'(exp_q[0].seq));
                checkOutput("stall_len", 64'(tx_pkt_payload_len), 64'(exp_q[0].len));
                checkOutput("stall_flags", 64'(tx_pkt_flags), 64'(exp_q[0].flags));
            end
            checkOutput("stall_val", 64'(tx_pkt_val), 64'd1);
            checkOutput("stall_sched_rdy", 64'(sched_req_rdy), 64'd0);
            checkOutput("stall_wr_val", 64'(tx_seq_wr_val), 64'd0);
        end
        rdy_mode = 1;
        @(posedge clk);
        #1;
        n = 0;
        while (tx_pkt_val && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("stall_release", 64'(tx_pkt_val), 64'd0);

        $display("[TB] reset during OUT");
        rdy_mode = 0;
        applyStimulus(3'd2, 32'd100, 32'd100, 32'd12, 16'd5000, 16'd44, 17'd400, 1'b0, 1'b0, sent);
        n = 0;
        while (!tx_pkt_val && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rst_pre_val", 64'(tx_pkt_val), 64'd1);
        rst = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        checkOutput("rst_cycle_wr_val", 64'(tx_seq_wr_val), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_val_dropped", 64'(tx_pkt_val), 64'd0);
        checkOutput("rst_sched_rdy", 64'(sched_req_rdy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_release_rdy", 64'(sched_req_rdy), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("rst_no_descriptor", 64'(tx_pkt_val), 64'd0);

        $display("[TB] random phase");
        rdy_mode = 2;
        for (int c = 0; c < 300; c++) begin
            flow = FLOWID_W'($urandom_range(0, 7));
            seq  = $urandom;
            case ($urandom_range(0, 3))
                0:       acked = seq;
                1:       acked = seq - 32'($urandom_range(0, 3000));
                2:       acked = seq - 32'($urandom_range(3000, 70000));
                default: acked = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       off = 0;
                1:       off = $urandom_range(1, 600);
                2:       off = $urandom_range(600, 5000);
                default: off = $urandom_range(0, 131071);
            endcase
            applyStimulus(flow, seq, acked, $urandom, 16'($urandom), 16'($urandom),
                          17'(seq + 32'(off)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), sent);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
